// File: rtl/mult_pkg.sv
// Shared state encoding for the sequential shift-add multiplier.
package mult_pkg;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_ADD_ENC   = 2'd1;
  localparam logic [1:0] ST_SHIFT_ENC = 2'd2;
  localparam logic [1:0] ST_DONE_ENC  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_ADD   = ST_ADD_ENC,
    ST_SHIFT = ST_SHIFT_ENC,
    ST_DONE  = ST_DONE_ENC
  } mult_state_t;

endpackage

// File: rtl/mult_addsub.sv
// (WIDTH+1)-bit adder/subtractor; operands are sign- or zero-extended by one bit.
module mult_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] s,
  input  logic             sub,
  input  logic             sign_ext,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] s_ext;

  assign a_ext = {sign_ext & a[WIDTH-1], a};
  assign s_ext = {sign_ext & s[WIDTH-1], s};
  assign sum   = sub ? (a_ext - s_ext) : (a_ext + s_ext);

endmodule

// File: rtl/mult_seq_n.sv
// Sequential shift-add multiplier: product accumulates in {A,B}, X extends A.
// One ADD/SHIFT pair per multiplier bit; the last step subtracts in signed mode.
module mult_seq_n
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             ClearA_LoadB,
  input  logic             Run,
  input  logic             Signed_Mode,
  input  logic [WIDTH-1:0] Switches,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       State_Dbg
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mult_state_t      state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             x_q, x_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   sum;
  logic             last_step;

  assign last_step = (cnt_q == CNT_LAST);

  // The sign bit of the multiplier has negative weight, hence subtract on the final step.
  mult_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a        (a_q),
    .s        (s_q),
    .sub      (mode_q & last_step),
    .sign_ext (mode_q),
    .sum      (sum)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    x_d     = x_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (ClearA_LoadB) begin
          a_d = '0;
          x_d = 1'b0;
          b_d = Switches;
        end else if (Run) begin
          a_d     = '0;
          x_d     = 1'b0;
          s_d     = Switches;
          mode_d  = Signed_Mode;
          cnt_d   = '0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        if (b_q[0]) begin
          {x_d, a_d} = sum;
        end
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        // Unsigned mode lets the carry in X drop into A and refills X with zero.
        x_d = mode_q & x_q;
        a_d = {x_q, a_q[WIDTH-1:1]};
        b_d = {a_q[0], b_q[WIDTH-1:1]};
        if (last_step) begin
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_ADD;
        end
      end
      ST_DONE: begin
        if (!Run) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      x_q     <= 1'b0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      x_q     <= x_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Aval      = a_q;
  assign Bval      = b_q;
  assign X         = x_q;
  assign Busy      = (state_q == ST_ADD) || (state_q == ST_SHIFT);
  assign Done      = (state_q == ST_DONE);
  assign State_Dbg = state_q;

endmodule

// File: tb/tb_mult_seq_n.sv
// Randomised scoreboard bench for mult_seq_n at WIDTH=8, plus WIDTH=16 spot checks.
module tb_mult_seq_n;

  typedef struct {
    logic [15:0] prod;
    logic        x;
    int          start;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        clr_ld;
  logic        run;
  logic        sgn;
  logic [7:0]  sw;
  logic [7:0]  aval;
  logic [7:0]  bval;
  logic        x;
  logic        busy;
  logic        done;
  logic [1:0]  st;

  logic        rst16;
  logic        clr16;
  logic        run16;
  logic        sgn16;
  logic [15:0] sw16;
  logic [15:0] aval16;
  logic [15:0] bval16;
  logic        x16;
  logic        busy16;
  logic        done16;
  logic [1:0]  st16;

  int          tests;
  int          fails;
  int          cyc;
  bit          fin8;
  bit          fin16;
  logic [7:0]  b_model;
  exp_t        sb_q[$];

  mult_seq_n #(.WIDTH(8)) u_dut8 (
    .Clk(clk), .Reset_n(rst_n), .ClearA_LoadB(clr_ld), .Run(run),
    .Signed_Mode(sgn), .Switches(sw), .Aval(aval), .Bval(bval), .X(x),
    .Busy(busy), .Done(done), .State_Dbg(st)
  );

  mult_seq_n #(.WIDTH(16)) u_dut16 (
    .Clk(clk), .Reset_n(rst16), .ClearA_LoadB(clr16), .Run(run16),
    .Signed_Mode(sgn16), .Switches(sw16), .Aval(aval16), .Bval(bval16), .X(x16),
    .Busy(busy16), .Done(done16), .State_Dbg(st16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer multiply of the operands as interpreted in the chosen mode.
  function automatic logic [31:0] ref_mul(input int w, input bit sg,
                                          input logic [15:0] b, input logic [15:0] s);
    longint bi;
    longint si;
    longint p;
    logic [63:0] pp;
    logic [31:0] mask;
    bi = longint'(b);
    si = longint'(s);
    if (sg && b[w-1]) bi = bi - (longint'(1) << w);
    if (sg && s[w-1]) si = si - (longint'(1) << w);
    p    = bi * si;
    pp   = p;
    mask = (w == 16) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    return pp[31:0] & mask;
  endfunction

  // Monitor: every rising Done must match the oldest outstanding expectation.
  initial begin
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && done && !done_prev) begin
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: got {A,B}=%h with no operation pending", {aval, bval});
        end else begin
          e = sb_q.pop_front();
          if ({aval, bval} !== e.prod || x !== e.x || (cyc - e.start) != 16) begin
            fails++;
            $display("FAIL product: got {A,B}=%h X=%b lat=%0d, want %h X=%b lat=16",
                     {aval, bval}, x, cyc - e.start, e.prod, e.x);
          end else begin
            $display("[TB] op ok: {A,B}=%h X=%b lat=%0d", {aval, bval}, x, cyc - e.start);
          end
        end
      end
      done_prev = done;
    end
  end

  task automatic check(input string name, input bit ok, input logic [31:0] got,
                       input logic [31:0] want);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end else begin
      $display("[TB] %s ok: %h", name, got);
    end
  endtask

  task automatic run_op(input bit sg, input logic [7:0] s, input bit do_load,
                        input logic [7:0] bl, input bit hold);
    exp_t e;
    logic [31:0] r;
    bit seen;
    if (do_load) begin
      clr_ld = 1'b1;
      sw     = bl;
      @(negedge clk);
      clr_ld  = 1'b0;
      b_model = bl;
    end
    sw  = s;
    sgn = sg;
    run = 1'b1;
    r = ref_mul(8, sg, {8'h00, b_model}, {8'h00, s});
    e.prod  = r[15:0];
    e.x     = sg & r[15];
    e.start = cyc + 1;
    sb_q.push_back(e);
    @(negedge clk);
    if (!hold) run = 1'b0;
    sw  = 8'($urandom);
    sgn = 1'($urandom);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: Done=%b state=%0d, want Done=1", done, st);
      sb_q.delete();
    end
    b_model = r[7:0];
    if (hold) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("run_held_stays_done", done && !busy && st == 2'd3, {30'd0, st}, 32'd3);
      end
      run = 1'b0;
    end
    @(negedge clk);
    check("back_to_idle", st == 2'd0 && !done, {30'd0, st}, 32'd0);
  endtask

  // WIDTH=8 stimulus
  initial begin
    clr_ld = 1'b0; run = 1'b0; sgn = 1'b0; sw = 8'h00; b_model = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_state", {aval, bval, x, busy, done, st} == '0,
          {aval, bval, x, busy, done, st[0]}, 32'd0);

    run_op(1'b1, 8'h3B, 1'b1, 8'h07, 1'b0);
    run_op(1'b1, 8'hC5, 1'b1, 8'h07, 1'b0);
    run_op(1'b1, 8'h3B, 1'b1, 8'h07, 1'b0);
    run_op(1'b1, 8'h02, 1'b0, 8'h00, 1'b0);
    run_op(1'b1, 8'hFF, 1'b1, 8'hFF, 1'b0);
    run_op(1'b0, 8'hFF, 1'b1, 8'hFF, 1'b0);
    run_op(1'b1, 8'h80, 1'b1, 8'h80, 1'b0);
    run_op(1'b0, 8'h80, 1'b1, 8'h80, 1'b0);
    run_op(1'b1, 8'h12, 1'b1, 8'h34, 1'b1);

    clr_ld = 1'b1; run = 1'b1; sw = 8'hA5;
    @(negedge clk);
    check("load_beats_run", !busy && bval == 8'hA5 && aval == 8'h00 && st == 2'd0,
          {8'h0, aval, bval, 6'd0, busy, st[0]}, 32'h0000_00A5);
    clr_ld = 1'b0; run = 1'b0; b_model = 8'hA5;
    @(negedge clk);
    check("no_start_after_load", !busy && st == 2'd0, {30'd0, st}, 32'd0);

    clr_ld = 1'b1; sw = 8'h55;
    @(negedge clk);
    clr_ld = 1'b0; sw = 8'h33; sgn = 1'b1; run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_midop", {aval, bval, x, busy, done, st} == '0,
             {aval, bval, x, busy, done, st[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    b_model = 8'h00;
    @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      run_op(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'b0);
    end
    check("scoreboard_drained", sb_q.size() == 0, sb_q.size(), 32'd0);
    fin8 = 1'b1;
  end

  task automatic run_w16(input bit sg, input logic [15:0] bl, input logic [15:0] s);
    logic [31:0] r;
    bit seen;
    clr16 = 1'b1;
    sw16  = bl;
    @(negedge clk);
    clr16 = 1'b0;
    sw16  = s;
    sgn16 = sg;
    run16 = 1'b1;
    @(negedge clk);
    run16 = 1'b0;
    sw16  = 16'($urandom);
    seen  = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (done16) seen = 1'b1;
    end
    r = ref_mul(16, sg, bl, s);
    check("w16_product", seen && {aval16, bval16} == r && x16 == (sg & r[31]),
          {aval16, bval16}, r);
    @(negedge clk);
  endtask

  // WIDTH=16 stimulus
  initial begin
    clr16 = 1'b0; run16 = 1'b0; sgn16 = 1'b0; sw16 = 16'h0000;
    rst16 = 1'b0;
    repeat (3) @(negedge clk);
    rst16 = 1'b1;
    @(negedge clk);
    check("w16_reset", {aval16, bval16, x16, busy16, done16} == '0, {aval16, bval16}, 32'd0);
    run_w16(1'b1, 16'h8001, 16'h7FFF);
    run_w16(1'b1, 16'h8000, 16'h8000);
    run_w16(1'b0, 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 5; i++) begin
      run_w16(1'($urandom), 16'($urandom), 16'($urandom));
    end
    fin16 = 1'b1;
  end

  initial begin
    wait (fin8 && fin16);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: bench still running, want completion");
    $fatal(1, "timeout");
  end

endmodule
